// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for the 5-stage MIPS core.
// Turns hazard, branch and SRAM-access requests into the freeze, flush and
// bubble controls for the pipeline registers. Also runs an SRAM wait-state
// sequencer that freezes the whole pipeline while memory is accessed, and
// keeps saturating stall and flush counters.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   hazard_detected    RAW hazard between ID and EX/MEM
//   branch_taken       ID-stage branch/jump resolved taken
//   mem_r_en, mem_w_en MEM-stage SRAM read / write
//   freeze_pc          hold PC
//   freeze_if_id       hold IF/ID
//   flush_if_id        load NOP into IF/ID
//   bubble_id_ex       load NOP into ID/EX
//   freeze_back        hold ID/EX, EX/MEM, MEM/WB
//   sram_ready         SRAM access complete, MEM may advance
//   stall_count        cycles with freeze_pc=1 (saturating)
//   flush_count        flushes issued (saturating)
module pipeline_stall_controller #(
  parameter int SRAM_WAIT = 5,
  parameter int CNT_W     = 32,
  parameter int FLUSH_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  output logic               freeze_pc,
  output logic               freeze_if_id,
  output logic               flush_if_id,
  output logic               bubble_id_ex,
  output logic               freeze_back,
  output logic               sram_ready,
  output logic [CNT_W-1:0]   stall_count,
  output logic [FLUSH_W-1:0] flush_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REL} state_t;

  localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mem_access;
  logic       mem_freeze;

  assign mem_access = mem_r_en | mem_w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (mem_access) begin
        cnt_nxt   = 4'd1;
        // A single-cycle access skips the wait state entirely.
        state_nxt = (SRAM_WAIT == 1) ? S_REL : S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST) state_nxt = S_REL;
      end
      // Release ignores mem_access so the same instruction can't retrigger.
      S_REL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // First access cycle is frozen combinationally, no latency.
  assign mem_freeze = ((state == S_IDLE) & mem_access) | (state == S_WAIT);

  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    freeze_back  = 1'b0;
    sram_ready   = 1'b0;
    if (!rst) begin
      sram_ready = (state == S_REL);
      if (mem_freeze) begin
        freeze_back  = 1'b1;
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
      end else if (hazard_detected) begin
        // Branch operands are stale under a hazard, so no flush.
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (branch_taken) begin
        flush_if_id  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (freeze_pc && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (flush_if_id && flush_count != '1)
        flush_count <= flush_count + FLUSH_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_r_en, mem_w_en;
  logic freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back, sram_ready;
  logic [31:0] stall_count;
  logic [15:0] flush_count;
  logic s_freeze_pc, s_freeze_if_id, s_flush_if_id, s_bubble_id_ex, s_freeze_back, s_sram_ready;
  logic [3:0]  s_stall_count;
  logic [15:0] s_flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.SRAM_WAIT(5), .CNT_W(32), .FLUSH_W(16)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .freeze_back(freeze_back), .sram_ready(sram_ready),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow stall counter instance for the saturation check.
  pipeline_stall_controller #(.SRAM_WAIT(5), .CNT_W(4), .FLUSH_W(16)) dut_sat (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .freeze_pc(s_freeze_pc), .freeze_if_id(s_freeze_if_id), .flush_if_id(s_flush_if_id),
    .bubble_id_ex(s_bubble_id_ex), .freeze_back(s_freeze_back), .sram_ready(s_sram_ready),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // Packed view of controls: {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back, sram_ready}
  function automatic logic [5:0] ctl();
    return {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back, sram_ready};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hazard_detected = 0; branch_taken = 0; mem_r_en = 0; mem_w_en = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    // Busy inputs during reset must still give all-zero controls.
    rst = 1; hazard_detected = 1; branch_taken = 1; mem_r_en = 1; mem_w_en = 0;
    #1;
    total++;
    if (ctl() !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=000000", ctl()); end
    tick();
    rst = 0; clear_inputs();
    #1;
    total++;
    if (ctl() !== 6'b0) begin bad++; $display("FAIL idle_ctl got=%b exp=000000", ctl()); end
    total++;
    if (stall_count !== 0 || flush_count !== 0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_count, flush_count);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    hazard_detected = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (ctl() !== 6'b110100) begin bad++; $display("FAIL hazard_ctl[%0d] got=%b exp=110100", i, ctl()); end
      tick();
    end
    hazard_detected = 0;
    #1;
    total++;
    if (ctl() !== 6'b0) begin bad++; $display("FAIL hazard_off got=%b exp=000000", ctl()); end
    total++;
    if (stall_count !== 32'd2) begin bad++; $display("FAIL hazard_stall got=%0d exp=2", stall_count); end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1;
    #1;
    total++;
    if (ctl() !== 6'b001000) begin bad++; $display("FAIL branch_ctl got=%b exp=001000", ctl()); end
    tick();
    hazard_detected = 1;
    #1;
    total++;
    if (ctl() !== 6'b110100) begin bad++; $display("FAIL branch_haz_ctl got=%b exp=110100", ctl()); end
    tick();
    clear_inputs();
    #1;
    total++;
    if (flush_count !== 16'd1 || stall_count !== 32'd1) begin
      bad++; $display("FAIL branch_cnt got=%0d/%0d exp=1/1", flush_count, stall_count);
    end
  endtask

  task automatic test_mem_read();
    logic [5:0] exp;
    do_reset();
    mem_r_en = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i < 5) ? 6'b110010 : 6'b000001;
      total++;
      if (ctl() !== exp) begin bad++; $display("FAIL mem_rd_ctl[%0d] got=%b exp=%b", i, ctl(), exp); end
      tick();
    end
    mem_r_en = 0;
    #1;
    total++;
    if (ctl() !== 6'b0) begin bad++; $display("FAIL mem_rd_after got=%b exp=000000", ctl()); end
    total++;
    if (stall_count !== 32'd5) begin bad++; $display("FAIL mem_rd_stall got=%0d exp=5", stall_count); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    do_reset();
    mem_w_en = 1; hazard_detected = 1; branch_taken = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      // Release cycle: hazard wins over branch, ready high.
      exp = ((i % 6) < 5) ? 6'b110010 : 6'b110101;
      total++;
      if (ctl() !== exp) begin bad++; $display("FAIL b2b_ctl[%0d] got=%b exp=%b", i, ctl(), exp); end
      tick();
    end
    clear_inputs();
    #1;
    total++;
    if (flush_count !== 16'd0) begin bad++; $display("FAIL b2b_flush got=%0d exp=0", flush_count); end
    total++;
    if (stall_count !== 32'd12) begin bad++; $display("FAIL b2b_stall got=%0d exp=12", stall_count); end
  endtask

  task automatic test_reset_mid_wait();
    logic [5:0] exp;
    do_reset();
    mem_r_en = 1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1;
    #1;
    total++;
    if (ctl() !== 6'b0) begin bad++; $display("FAIL midrst_ctl got=%b exp=000000", ctl()); end
    tick();
    rst = 0;
    #1;
    total++;
    if (stall_count !== 32'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", stall_count); end
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i < 5) ? 6'b110010 : 6'b000001;
      total++;
      if (ctl() !== exp) begin bad++; $display("FAIL midrst_seq[%0d] got=%b exp=%b", i, ctl(), exp); end
      tick();
    end
    mem_r_en = 0;
    #1;
    total++;
    if (stall_count !== 32'd5) begin bad++; $display("FAIL midrst_stall got=%0d exp=5", stall_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    hazard_detected = 1;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (s_stall_count !== 4'hF) begin bad++; $display("FAIL sat_reach got=%0d exp=15", s_stall_count); end
    for (int i = 0; i < 5; i++) tick();
    hazard_detected = 0;
    #1;
    total++;
    if (s_stall_count !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0d exp=15", s_stall_count); end
    total++;
    if (stall_count !== 32'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", stall_count); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #2;
    test_reset();
    test_hazard();
    test_branch();
    test_mem_read();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard-detection result, the ID-stage branch decision and MEM-stage memory requests, and drives every freeze, flush and bubble control in the 5-stage MIPS pipeline.
- Adds a multi-cycle SRAM wait-state sequencer that globally freezes the pipeline during memory accesses.
- Keeps saturating stall and flush performance counters.
- Sits in the top-level core between the hazard unit and the pipeline registers.

Parameters:
- SRAM_WAIT, 5, frozen cycles per SRAM access; legal range 1..15.
- CNT_W, 32, width of stall_count.
- FLUSH_W, 16, width of flush_count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- hazard_detected  in  1  RAW hazard from the hazard unit (ID vs EX/MEM destinations)
- branch_taken  in  1  ID-stage branch/jump resolved taken
- mem_r_en  in  1  MEM-stage instruction reads SRAM
- mem_w_en  in  1  MEM-stage instruction writes SRAM
- freeze_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID register
- flush_if_id  out  1  load NOP into IF/ID
- bubble_id_ex  out  1  load NOP (all control bits zero) into ID/EX
- freeze_back  out  1  hold ID/EX, EX/MEM, MEM/WB
- sram_ready  out  1  SRAM data valid / write committed, MEM stage may advance
- stall_count  out  CNT_W  cycles with freeze_pc=1, saturating
- flush_count  out  FLUSH_W  flushes issued, saturating

Behaviour:
- Memory sequencer FSM has three states: IDLE, WAIT, RELEASE.
  - mem_access = mem_r_en | mem_w_en.
  - IDLE -> WAIT when mem_access; wait counter loads 1.
  - WAIT: counter increments each cycle. When counter == SRAM_WAIT-1 at a clock edge, go to RELEASE.
  - With SRAM_WAIT=1, IDLE goes directly to RELEASE.
  - RELEASE -> IDLE unconditionally. mem_access is ignored in RELEASE, so the same instruction never retriggers.
  - Each access therefore freezes exactly SRAM_WAIT cycles, followed by 1 release cycle.
- mem_freeze = (IDLE & mem_access) | WAIT. This is combinational, so the first cycle is frozen with no latency.
- sram_ready = 1 only in RELEASE.
- Output priority, highest first:
  - mem_freeze: freeze_back=1, freeze_pc=1, freeze_if_id=1, bubble_id_ex=0, flush_if_id=0.
  - else hazard_detected: freeze_pc=1, freeze_if_id=1, bubble_id_ex=1. branch_taken is ignored because its operands are stale, so flush_if_id=0.
  - else branch_taken: flush_if_id=1; all freezes and the bubble are 0.
  - else all controls are 0.
- All control outputs are combinational from state and inputs, with no added latency.
- Counters update on the clock edge:
  - stall_count +1 when freeze_pc=1.
  - flush_count +1 when flush_if_id=1.
  - Both hold at all-ones and never wrap.
- Reset:
  - state=IDLE, wait counter=0, stall_count=0, flush_count=0.
  - During the reset cycle all control outputs and sram_ready are forced to 0.
  - A reset mid-WAIT abandons the access. After reset a still-asserted mem_access starts a fresh full wait.
- Simultaneous events:
  - mem_access with hazard and branch in the same cycle: only the freeze applies.
  - Hazard and branch resolve after the release cycle, on the then-current inputs.
- Back-to-back accesses: a new mem_access in the cycle after RELEASE (IDLE) starts a new wait immediately.

Test Plan:
- Reset, then release with all inputs 0 -> all controls 0, stall_count=0, flush_count=0.
- hazard_detected=1 for 2 cycles -> freeze_pc=freeze_if_id=bubble_id_ex=1 for 2 cycles, stall_count=2.
- branch_taken=1 for 1 cycle, then hazard+branch together for 1 cycle -> flush_if_id=1 only in the first cycle, flush_count=1, bubble in the second cycle.
- SRAM_WAIT=5, mem_r_en held for 6 cycles -> freeze_back=1 for cycles 0-4, sram_ready=1 in cycle 5 only, no retrigger, stall_count=5.
- Two mem_w_en back-to-back (held 6 + 6 cycles) with hazard_detected=1 and branch_taken=1 throughout -> 2 x (5 frozen + 1 release). No bubble or flush during frozen cycles; hazard bubble in each release cycle; flush_count=0.
- rst pulsed in cycle 3 of a WAIT with mem_r_en still high -> outputs 0 during reset; a new 5-cycle freeze starts the next cycle; counters restart from 0.
- Force stall_count to all-ones via CNT_W=4 and 20 hazard cycles -> stall_count holds at 15.
